// File: rtl/apb_master_pkg.sv
// Shared types and constants for the two-requester APB master arbiter.
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int STB_WIDTH = 4;

endpackage

// File: rtl/apb_rr_pick.sv
// Two-way round-robin picker: a lone requester wins; on a tie the one
// that was not granted last time wins.
module apb_rr_pick
    import apb_master_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    // NOTE: every output gets a default before any branch, so no latch is inferred.
    always_comb begin
        grant_valid = |req;
        grant_idx   = M0;
        if (req == 2'b11) begin
            grant_idx = ~last_grant;
        end else if (req[1]) begin
            grant_idx = M1;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by an instruction-fetch port (m0) and a load/store port (m1):
// round-robin grant, SETUP/ACCESS sequencing, response routing and wait-state timeout.
module apb_master_arbiter
    import apb_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  pclk,
    input  logic                  reset,

    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m0_write,
    input  logic [STB_WIDTH-1:0]  m0_stb,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_err,

    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_write,
    input  logic [STB_WIDTH-1:0]  m1_stb,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_err,

    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    output logic                  pwrite,
    output logic [STB_WIDTH-1:0]  pstb,
    output logic                  psel,
    output logic                  penable,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  perr
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    apb_state_t            state;
    apb_state_t            state_next;
    logic                  last_grant;
    logic                  owner;
    logic [CNT_W-1:0]      tmo_cnt;
    logic                  grant_valid;
    logic                  grant_idx;
    logic                  done;
    logic                  ack;
    logic                  timed_out;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    apb_rr_pick u_pick (
        .req         ({m1_req, m0_req}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // tmo_cnt holds the number of ACCESS cycles already spent, so the
    // TIMEOUT_CYCLES-th ACCESS cycle is the one that sees CNT_LAST.
    assign timed_out = (tmo_cnt >= CNT_LAST);

    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            IDLE:    if (grant_valid) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS: begin
                if (pready || timed_out) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A completion coinciding with reset is dropped; the requester retries.
    assign ack        = done && !reset;
    assign resp_rdata = pready ? prdata : '0;
    assign resp_err   = pready ? perr : 1'b1;

    assign m0_ack   = ack && (owner == M0);
    assign m1_ack   = ack && (owner == M1);
    assign m0_rdata = m0_ack ? resp_rdata : '0;
    assign m1_rdata = m1_ack ? resp_rdata : '0;
    assign m0_err   = m0_ack && resp_err;
    assign m1_err   = m1_ack && resp_err;

    assign psel    = (state != IDLE);
    assign penable = (state == ACCESS);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= M1;
            owner      <= M0;
            paddr      <= '0;
            pdata      <= '0;
            pwrite     <= 1'b0;
            pstb       <= '0;
            tmo_cnt    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && grant_valid) begin
                owner      <= grant_idx;
                last_grant <= grant_idx;
                if (grant_idx == M1) begin
                    paddr  <= m1_addr;
                    pdata  <= m1_wdata;
                    pwrite <= m1_write;
                    pstb   <= m1_write ? m1_stb : '0;
                end else begin
                    paddr  <= m0_addr;
                    pdata  <= m0_wdata;
                    pwrite <= m0_write;
                    pstb   <= m0_write ? m0_stb : '0;
                end
            end
            if (state == SETUP) begin
                tmo_cnt <= '0;
            end else if (state == ACCESS && tmo_cnt != CNT_MAX) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed and randomized checks of apb_master_arbiter against a transaction-level model.
module tb_apb_master_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          pclk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic          write [2];
    logic [3:0]    stb   [2];
    logic          m0_ack, m1_ack, m0_err, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pdata, prdata;
    logic          pwrite, psel, penable, pready, perr;
    logic [3:0]    pstb;

    always #5 pclk = ~pclk;

    apb_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .reset(reset),
        .m0_req(req[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_write(write[0]),
        .m0_stb(stb[0]), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(req[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_write(write[1]),
        .m1_stb(stb[1]), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .paddr(paddr), .pdata(pdata), .pwrite(pwrite), .pstb(pstb),
        .psel(psel), .penable(penable), .prdata(prdata), .pready(pready), .perr(perr)
    );

    int vectors = 0;
    int miscompares = 0;

    // Transaction-level model: a transfer in flight, its phase position
    // (0 = select cycle, k = k-th enable cycle) and who went last.
    bit            mb_busy = 1'b0;
    int            mb_pos = 0;
    int            mb_owner = 0;
    int            mb_last = 1;
    logic [AW-1:0] mb_addr;
    logic [DW-1:0] mb_wdata;
    logic          mb_write;
    logic [3:0]    mb_stb;

    logic          s_psel, s_pen, s_pwrite;
    logic [AW-1:0] s_paddr;
    logic [DW-1:0] s_pdata;
    logic [3:0]    s_pstb;
    logic          s_ack [2];
    logic          s_err [2];
    logic [DW-1:0] s_rdata [2];
    bit            e_ack [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic new_txn(input int i);
        addr[i]  = $urandom;
        wdata[i] = $urandom;
        write[i] = 1'($urandom_range(0, 1));
        stb[i]   = 4'($urandom_range(0, 15));
    endtask

    // One clock: sample/compare at the falling edge, advance the model, then
    // return just after the rising edge so the caller can drive new inputs.
    task automatic cycle();
        bit            e_pen, done;
        bit            e_err [2];
        logic [DW-1:0] e_rdata [2];
        int            w;
        @(negedge pclk);
        s_psel = psel; s_pen = penable; s_paddr = paddr; s_pdata = pdata;
        s_pwrite = pwrite; s_pstb = pstb;
        s_ack[0] = m0_ack; s_err[0] = m0_err; s_rdata[0] = m0_rdata;
        s_ack[1] = m1_ack; s_err[1] = m1_err; s_rdata[1] = m1_rdata;

        e_pen = mb_busy && mb_pos >= 1;
        done  = e_pen && !reset && (pready || mb_pos == TO);
        for (int i = 0; i < 2; i++) begin
            e_ack[i]   = done && mb_owner == i;
            e_err[i]   = e_ack[i] && (pready ? perr : 1'b1);
            e_rdata[i] = (e_ack[i] && pready) ? prdata : '0;
        end
        check("psel", s_psel, mb_busy);
        check("penable", s_pen, e_pen);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("m%0d_ack", i), s_ack[i], e_ack[i]);
            check($sformatf("m%0d_err", i), s_err[i], e_err[i]);
            check($sformatf("m%0d_rdata", i), s_rdata[i], e_rdata[i]);
        end
        if (mb_busy) begin
            check("paddr", s_paddr, mb_addr);
            check("pdata", s_pdata, mb_wdata);
            check("pwrite", s_pwrite, mb_write);
            check("pstb", s_pstb, mb_write ? mb_stb : 4'h0);
        end

        if (reset) begin
            mb_busy = 1'b0;
            mb_last = 1;
        end else if (!mb_busy) begin
            w = -1;
            if (req == 2'b11) w = 1 - mb_last;
            else if (req[0]) w = 0;
            else if (req[1]) w = 1;
            if (w >= 0) begin
                mb_busy = 1'b1; mb_pos = 0; mb_owner = w; mb_last = w;
                mb_addr = addr[w]; mb_wdata = wdata[w]; mb_write = write[w]; mb_stb = stb[w];
            end
        end else if (done) begin
            mb_busy = 1'b0;
        end else begin
            mb_pos++;
        end
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    int thr_tab [3] = '{85, 40, 4};
    int thr;

    initial begin
        reset = 1'b1; req = 2'b00; pready = 1'b0; perr = 1'b0; prdata = '0;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; wdata[i] = '0; write[i] = 1'b0; stb[i] = 4'h0;
        end
        cycle();
        cycle();
        check("rst_psel", s_psel, 1'b0);
        check("rst_penable", s_pen, 1'b0);
        check("rst_paddr", s_paddr, 32'h0);
        check("rst_pdata", s_pdata, 32'h0);
        check("rst_pwrite", s_pwrite, 1'b0);
        check("rst_pstb", s_pstb, 4'h0);
        check("rst_ack", {s_ack[1], s_ack[0]}, 2'b00);
        reset = 1'b0;

        // Single m0 read, zero wait states.
        req[0] = 1'b1; addr[0] = 32'h8000_0010; write[0] = 1'b0; stb[0] = 4'hF;
        pready = 1'b1; prdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 4; c++) begin
            cycle();
            if (c == 1) begin
                check("t1_psel_c1", s_psel, 1'b1);
                check("t1_pen_c1", s_pen, 1'b0);
                check("t1_paddr", s_paddr, 32'h8000_0010);
                check("t1_pstb_read", s_pstb, 4'h0);
            end
            if (c == 2) begin
                check("t1_ack", s_ack[0], 1'b1);
                check("t1_rdata", s_rdata[0], 32'hDEAD_BEEF);
                check("t1_err", s_err[0], 1'b0);
                check("t1_m1_quiet", {s_ack[1], s_err[1]}, 2'b00);
                req[0] = 1'b0;
            end
        end

        // Both continuous from reset: strict alternation, 3 cycles apart.
        do_reset();
        req = 2'b11; addr[0] = 32'h100; write[0] = 1'b0;
        addr[1] = 32'h0100_0000; wdata[1] = 32'h41; write[1] = 1'b1; stb[1] = 4'hF;
        for (int c = 0; c < 12; c++) begin
            cycle();
            check($sformatf("t2_ack0_c%0d", c), s_ack[0], (c == 2 || c == 8));
            check($sformatf("t2_ack1_c%0d", c), s_ack[1], (c == 5 || c == 11));
            if (c == 4 || c == 5) begin
                check("t2_m1_paddr", s_paddr, 32'h0100_0000);
                check("t2_m1_pdata", s_pdata, 32'h41);
                check("t2_m1_pstb", s_pstb, 4'hF);
                check("t2_m1_pwrite", s_pwrite, 1'b1);
            end
        end
        req = 2'b00;

        // m1 read, 4 wait states, address changed after grant.
        do_reset();
        req[1] = 1'b1; addr[1] = 32'h3000; write[1] = 1'b0; pready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            pready = (c == 6);
            cycle();
            if (c == 0) addr[1] = 32'hFFFF_0000;
            if (c >= 1 && c <= 6) check($sformatf("t3_paddr_c%0d", c), s_paddr, 32'h3000);
            check($sformatf("t3_ack_c%0d", c), s_ack[1], (c == 6));
            if (c == 6) req[1] = 1'b0;
        end

        // Decode fault: timeout after TO enable cycles, then pready on that same cycle.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            req[0] = 1'b1; addr[0] = 32'h2000; write[0] = 1'b0; perr = 1'b1;
            prdata = 32'hCAFE_F00D;
            for (int c = 0; c < 11; c++) begin
                pready = (pass == 1 && c == 9);
                cycle();
                if (c == 8) check("t4_no_early_ack", s_ack[0], 1'b0);
                if (c == 9) begin
                    check($sformatf("t4_ack_p%0d", pass), s_ack[0], 1'b1);
                    check($sformatf("t4_err_p%0d", pass), s_err[0], 1'b1);
                    check($sformatf("t4_rdata_p%0d", pass), s_rdata[0],
                          (pass == 1) ? 32'hCAFE_F00D : 32'h0);
                    req[0] = 1'b0;
                end
                if (c == 10) check("t4_idle_psel", s_psel, 1'b0);
            end
            perr = 1'b0; pready = 1'b0;
        end

        // Reset during the second enable cycle of a write.
        do_reset();
        req[0] = 1'b1; addr[0] = 32'h4000; wdata[0] = 32'h55; write[0] = 1'b1; stb[0] = 4'h3;
        pready = 1'b0;
        cycle(); cycle(); cycle();
        reset = 1'b1; pready = 1'b1; req[0] = 1'b0;
        req[1] = 1'b1; addr[1] = 32'h5000; write[1] = 1'b0;
        cycle();
        check("t6_no_ack", {s_ack[1], s_ack[0]}, 2'b00);
        reset = 1'b0;
        cycle();
        check("t6_psel_drop", s_psel, 1'b0);
        check("t6_pen_drop", s_pen, 1'b0);
        check("t6_paddr_zero", s_paddr, 32'h0);
        cycle();
        check("t6_m1_granted", s_paddr, 32'h5000);
        cycle();
        check("t6_m1_ack", s_ack[1], 1'b1);
        req[1] = 1'b0;

        // Randomized traffic with varying slave latency and occasional resets.
        thr = 85;
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) thr = thr_tab[$urandom_range(0, 2)];
            pready = ($urandom_range(0, 99) < thr);
            perr   = ($urandom_range(0, 7) == 0);
            prdata = $urandom;
            reset  = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    new_txn(i);
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(0, 4) == 0) begin
                    new_txn(i);
                end
            end
            cycle();
            for (int i = 0; i < 2; i++) begin
                if (e_ack[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                    if (req[i]) new_txn(i);
                end
            end
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Two-requester APB master that shares the single APB bus in front of the address decoder between the instruction-fetch port (m0) and the load/store port (m1).
- Arbitrates round-robin, latches the winner's request, and drives SETUP/ACCESS phases.
- Returns the response, with read data, error and a wait-state timeout, to the granted requester.

Parameters:
ADDR_WIDTH, 32, address width of requesters and paddr
DATA_WIDTH, 32, data width of wdata/rdata/pdata/prdata
TIMEOUT_CYCLES, 256, max ACCESS cycles without pready before abort (>=1)

Ports:
pclk  in  1  clock, all logic on rising edge
reset  in  1  synchronous active-high reset
m0_req  in  1  request, level, held until m0_ack
m0_addr  in  ADDR_WIDTH  request address
m0_wdata  in  DATA_WIDTH  write data
m0_write  in  1  1=write, 0=read
m0_stb  in  4  byte strobes (writes)
m0_ack  out  1  one-cycle completion pulse
m0_rdata  out  DATA_WIDTH  read data, valid with m0_ack
m0_err  out  1  error, valid with m0_ack
m1_*  same set as m0_* for requester 1
paddr  out  ADDR_WIDTH  APB address
pdata  out  DATA_WIDTH  APB write data
pwrite  out  1  APB direction
pstb  out  4  APB strobes, 0 on reads
psel  out  1  APB select
penable  out  1  APB enable
prdata  in  DATA_WIDTH  APB read data
pready  in  1  APB ready
perr  in  1  APB slave/decode error

Behaviour:
- Reset is synchronous and active-high on pclk.
  - On reset: state=IDLE, psel=penable=pwrite=0, paddr=pdata=pstb=0, last_grant=1 (m0 wins first tie), timeout counter=0, no ack or err.
- States IDLE, SETUP, ACCESS.
- IDLE:
  - No req: stay.
  - One req: grant it.
  - Both req: grant the one not equal to last_grant.
  - On grant: latch addr, wdata, write and stb (stb forced 0 when write=0) into paddr/pdata/pwrite/pstb; set last_grant and owner; next state SETUP.
- SETUP: psel=1, penable=0. Always go to ACCESS next cycle.
- ACCESS: psel=1, penable=1. Count cycles.
  - pready=1: completion this cycle. owner ack=1, owner rdata=prdata (combinational pass-through), owner err=perr. Next state IDLE, psel/penable -> 0.
  - pready=0 and count reaches TIMEOUT_CYCLES: abort. owner ack=1, err=1, rdata=0. Next state IDLE.
- Minimum 3 cycles per transfer: SETUP, ACCESS, IDLE bubble.
  - The IDLE bubble guarantees the acked requester has deasserted or renewed req before re-arbitration.
- paddr/pdata/pwrite/pstb are stable from SETUP through the last ACCESS cycle. Requester inputs are sampled only at grant; changes after grant are ignored.
- The non-owner's ack, err and rdata are 0 at all times. The owner's are 0 except in the completion cycle.
- Read with perr=1: rdata still passes prdata; err=1.
- Write: rdata=prdata (don't-care for requester).
- Timeout counter:
  - Width clog2(TIMEOUT_CYCLES+1).
  - Cleared on entering ACCESS; saturates and never wraps.
  - TIMEOUT_CYCLES=1 means the first ACCESS cycle without pready aborts.
- pready and timeout reaching limit in the same cycle: pready wins, normal completion, err=perr.
- pready/perr are ignored outside ACCESS.
- Reset mid-transfer: bus outputs drop at the next edge and no ack is issued; the requester must retry.
- Fairness: under continuous requests from both, grants strictly alternate.

Decomposition:
- Package apb_master_pkg:
  - state enum (IDLE, SETUP, ACCESS)
  - owner index constants M0=0, M1=1
  - STB_WIDTH=4
- One sub-module, apb_rr_pick:
  - 2-way round-robin combinational picker
  - inputs req[1:0], last_grant; outputs grant_valid, grant_idx

Test Plan:
- m0 read addr 0x80000010, slave pready=1 first ACCESS cycle, prdata=0xDEADBEEF -> psel rises cycle 1, penable cycle 2; m0_ack=1 with m0_rdata=0xDEADBEEF, m0_err=0 in cycle 2; m1 outputs stay 0.
- m0 and m1 both request from reset, continuous -> grant order m0,m1,m0,m1; each transfer 3 cycles apart; m1 write 0x1000000 data 0x41 stb 0xF seen on pdata/pstb during its SETUP and ACCESS.
- m1 read with 4 wait states (pready low 4 ACCESS cycles) and m1_addr changed after grant -> paddr unchanged throughout; ack on 5th ACCESS cycle.
- m0 read addr 0x2000 with perr=1, pready=0 (decode fault) and TIMEOUT_CYCLES=8 -> after 8 ACCESS cycles m0_ack=1, m0_err=1, m0_rdata=0; IDLE next cycle.
- pready=1, perr=1 on the cycle the timeout would expire -> normal completion, err=1, rdata=prdata.
- reset asserted in ACCESS cycle 2 of a write -> psel=penable=0 next cycle, no ack; after release, a pending m1 req is granted first (last_grant=1 rule makes m0 win ties; with only m1 requesting, m1 granted).
